mau_flowmod_arbiter: RTL and testbench

MAU_FLOWMOD_ARBITER -- requirements
Module: mau_flowmod_arbiter

---
 rtl/mau_flowmod_arbiter.sv | 157 +++++++++++++++
 tb/tb_mau_flowmod_arbiter.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/mau_flowmod_arbiter.sv
// Round-robin arbiter that merges CSR and learn/age flowmod requesters onto the EM and flow-state tables.
// Command reaches a table one cycle after the grant; read data passes straight through. Timed-out reads return zero data.
module mau_flowmod_arbiter #(
    parameter int ADDR_WIDTH   = 24,
    parameter int DATA_WIDTH   = 134,
    parameter int OPCODE_WIDTH = 4,
    parameter int TIMEOUT      = 1024
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [ADDR_WIDTH-1:0]   s0_mod_addr,
    input  logic [DATA_WIDTH-1:0]   s0_mod_data,
    input  logic [OPCODE_WIDTH-1:0] s0_mod_opcode,
    input  logic                    s0_mod_valid,
    output logic                    s0_mod_ready,
    output logic [DATA_WIDTH-1:0]   s0_mod_bdata,
    output logic                    s0_mod_bvalid,
    input  logic                    s0_mod_bready,
    input  logic [ADDR_WIDTH-1:0]   s1_mod_addr,
    input  logic [DATA_WIDTH-1:0]   s1_mod_data,
    input  logic [OPCODE_WIDTH-1:0] s1_mod_opcode,
    input  logic                    s1_mod_valid,
    output logic                    s1_mod_ready,
    output logic [DATA_WIDTH-1:0]   s1_mod_bdata,
    output logic                    s1_mod_bvalid,
    input  logic                    s1_mod_bready,
    output logic [ADDR_WIDTH-1:0]   m_mod_addr,
    output logic [DATA_WIDTH-1:0]   m_mod_data,
    output logic [OPCODE_WIDTH-1:0] m_mod_opcode,
    output logic                    m_em_mod_valid,
    input  logic                    m_em_mod_ready,
    output logic                    m_st_mod_valid,
    input  logic                    m_st_mod_ready,
    input  logic [DATA_WIDTH-1:0]   m_em_mod_bdata,
    input  logic [DATA_WIDTH-1:0]   m_st_mod_bdata,
    input  logic                    m_em_mod_bvalid,
    input  logic                    m_st_mod_bvalid,
    output logic                    m_em_mod_bready,
    output logic                    m_st_mod_bready,
    output logic                    busy,
    output logic                    grant_id,
    output logic [15:0]             timeout_count
);
    localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, CMD, RESP} state_t;

    state_t                  r_state;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [DATA_WIDTH-1:0]   r_data;
    logic [OPCODE_WIDTH-1:0] r_opcode;
    logic                    r_owner, r_last, r_tgt_st, r_to, r_seen;
    logic [TW-1:0]           r_timer;
    logic [15:0]             r_tocnt;

    logic                  w_idle, w_cmd, w_resp, w_gnt0, w_gnt1, w_hs;
    logic                  w_tgt_rdy, w_tgt_bvld, w_expire, w_to;
    logic                  w_own_bvld, w_own_brdy, w_tgt_brdy;
    logic [DATA_WIDTH-1:0] w_tgt_bdat, w_own_bdat;

    // Reset overrides the state decode so outputs take their reset values in the rst cycle itself.
    assign w_idle = rst || (r_state == IDLE);
    assign w_cmd  = !rst && (r_state == CMD);
    assign w_resp = !rst && (r_state == RESP);

    // r_last == 1 means s1 was granted last, so s0 wins a tie.
    assign w_gnt1 = s1_mod_valid && (!s0_mod_valid || !r_last);
    assign w_gnt0 = s0_mod_valid && !w_gnt1;
    assign s0_mod_ready = !rst && (r_state == IDLE) && w_gnt0;
    assign s1_mod_ready = !rst && (r_state == IDLE) && w_gnt1;
    assign w_hs = s0_mod_ready || s1_mod_ready;

    assign m_mod_addr     = r_addr;
    assign m_mod_data     = r_data;
    assign m_mod_opcode   = r_opcode;
    assign m_em_mod_valid = w_cmd && !r_tgt_st;
    assign m_st_mod_valid = w_cmd && r_tgt_st;

    assign w_tgt_rdy  = r_tgt_st ? m_st_mod_ready  : m_em_mod_ready;
    assign w_tgt_bvld = r_tgt_st ? m_st_mod_bvalid : m_em_mod_bvalid;
    assign w_tgt_bdat = r_tgt_st ? m_st_mod_bdata  : m_em_mod_bdata;

    // Expiry only fires without a target bvalid, so real data arriving on the last cycle wins.
    assign w_expire   = w_resp && !r_to && !r_seen && !w_tgt_bvld && (r_timer == TMAX);
    assign w_to       = r_to || w_expire;
    assign w_own_bvld = w_resp && (w_to || w_tgt_bvld);
    assign w_own_bdat = w_to ? '0 : w_tgt_bdat;
    assign w_own_brdy = r_owner ? s1_mod_bready : s0_mod_bready;
    assign w_tgt_brdy = w_resp && !w_to && w_own_brdy;

    assign s0_mod_bvalid = w_own_bvld && !r_owner;
    assign s1_mod_bvalid = w_own_bvld && r_owner;
    assign s0_mod_bdata  = (w_resp && !r_owner) ? w_own_bdat : '0;
    assign s1_mod_bdata  = (w_resp && r_owner)  ? w_own_bdat : '0;

    // Idle breadys drain stale readbacks left over from timed-out reads.
    assign m_em_mod_bready = w_idle || (!r_tgt_st && w_tgt_brdy);
    assign m_st_mod_bready = w_idle || (r_tgt_st && w_tgt_brdy);

    assign busy          = !rst && (r_state != IDLE);
    assign grant_id      = !rst && r_owner;
    assign timeout_count = rst ? 16'h0 : r_tocnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_addr   <= '0;
            r_data   <= '0;
            r_opcode <= '0;
            r_owner  <= 1'b0;
            r_last   <= 1'b1;
            r_tgt_st <= 1'b0;
            r_to     <= 1'b0;
            r_seen   <= 1'b0;
            r_timer  <= '0;
            r_tocnt  <= 16'h0;
        end else begin
            case (r_state)
                IDLE: if (w_hs) begin
                    r_addr   <= w_gnt1 ? s1_mod_addr   : s0_mod_addr;
                    r_data   <= w_gnt1 ? s1_mod_data   : s0_mod_data;
                    r_opcode <= w_gnt1 ? s1_mod_opcode : s0_mod_opcode;
                    r_tgt_st <= w_gnt1 ? (s1_mod_opcode[3:2] == 2'b11)
                                       : (s0_mod_opcode[3:2] == 2'b11);
                    r_owner  <= w_gnt1;
                    r_last   <= w_gnt1;
                    r_state  <= CMD;
                end
                CMD: if (w_tgt_rdy) begin
                    if (r_opcode[1:0] == 2'b01) begin
                        r_state <= RESP;
                        r_timer <= '0;
                        r_to    <= 1'b0;
                        r_seen  <= 1'b0;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                RESP: begin
                    if (w_tgt_bvld)
                        r_seen <= 1'b1;
                    if (!r_seen && !w_tgt_bvld && !r_to && (r_timer != TMAX))
                        r_timer <= r_timer + TW'(1);
                    if (w_expire) begin
                        r_to <= 1'b1;
                        if (r_tocnt != 16'hFFFF)
                            r_tocnt <= r_tocnt + 16'h1;
                    end
                    if (w_own_bvld && w_own_brdy)
                        r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mau_flowmod_arbiter.sv
// Directed bench for mau_flowmod_arbiter: round-robin writes, state-table read, timeout, expiry race, reset abandon.
module tb_mau_flowmod_arbiter;
    localparam int AW = 24, DW = 134, OW = 4, TO = 8;

    logic clk = 1'b0;
    logic rst;
    logic [AW-1:0] s0_mod_addr, s1_mod_addr, m_mod_addr;
    logic [DW-1:0] s0_mod_data, s1_mod_data, m_mod_data;
    logic [OW-1:0] s0_mod_opcode, s1_mod_opcode, m_mod_opcode;
    logic s0_mod_valid, s0_mod_ready, s0_mod_bvalid, s0_mod_bready;
    logic s1_mod_valid, s1_mod_ready, s1_mod_bvalid, s1_mod_bready;
    logic [DW-1:0] s0_mod_bdata, s1_mod_bdata, m_em_mod_bdata, m_st_mod_bdata;
    logic m_em_mod_valid, m_em_mod_ready, m_st_mod_valid, m_st_mod_ready;
    logic m_em_mod_bvalid, m_st_mod_bvalid, m_em_mod_bready, m_st_mod_bready;
    logic busy, grant_id;
    logic [15:0] timeout_count;

    int total = 0;
    int bad = 0;

    mau_flowmod_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .OPCODE_WIDTH(OW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .s0_mod_addr(s0_mod_addr), .s0_mod_data(s0_mod_data), .s0_mod_opcode(s0_mod_opcode),
        .s0_mod_valid(s0_mod_valid), .s0_mod_ready(s0_mod_ready),
        .s0_mod_bdata(s0_mod_bdata), .s0_mod_bvalid(s0_mod_bvalid), .s0_mod_bready(s0_mod_bready),
        .s1_mod_addr(s1_mod_addr), .s1_mod_data(s1_mod_data), .s1_mod_opcode(s1_mod_opcode),
        .s1_mod_valid(s1_mod_valid), .s1_mod_ready(s1_mod_ready),
        .s1_mod_bdata(s1_mod_bdata), .s1_mod_bvalid(s1_mod_bvalid), .s1_mod_bready(s1_mod_bready),
        .m_mod_addr(m_mod_addr), .m_mod_data(m_mod_data), .m_mod_opcode(m_mod_opcode),
        .m_em_mod_valid(m_em_mod_valid), .m_em_mod_ready(m_em_mod_ready),
        .m_st_mod_valid(m_st_mod_valid), .m_st_mod_ready(m_st_mod_ready),
        .m_em_mod_bdata(m_em_mod_bdata), .m_st_mod_bdata(m_st_mod_bdata),
        .m_em_mod_bvalid(m_em_mod_bvalid), .m_st_mod_bvalid(m_st_mod_bvalid),
        .m_em_mod_bready(m_em_mod_bready), .m_st_mod_bready(m_st_mod_bready),
        .busy(busy), .grant_id(grant_id), .timeout_count(timeout_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [135:0] got, input logic [135:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs are then driven at the falling edge and checked 1ns later.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        s0_mod_addr = 24'h000A0A; s0_mod_data = 134'h50; s0_mod_opcode = 4'h0; s0_mod_valid = 1'b0;
        s1_mod_addr = 24'h000B0B; s1_mod_data = 134'h51; s1_mod_opcode = 4'h0; s1_mod_valid = 1'b0;
        s0_mod_bready = 1'b0; s1_mod_bready = 1'b0;
        m_em_mod_ready = 1'b0; m_st_mod_ready = 1'b0;
        m_em_mod_bvalid = 1'b0; m_st_mod_bvalid = 1'b0;
        m_em_mod_bdata = '0; m_st_mod_bdata = '0;
        @(negedge clk);
        step();
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_grant", grant_id, 0);
        chk("rst_tocnt", timeout_count, 0);
        chk("rst_em_bready", m_em_mod_bready, 1);
        chk("rst_st_bready", m_st_mod_bready, 1);
        chk("rst_em_valid", m_em_mod_valid, 0);
        @(negedge clk);
        rst = 1'b0;

        // Consecutive tied writes alternate s0, s1, s0.
        s0_mod_valid = 1'b1; s1_mod_valid = 1'b1; m_em_mod_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("rr_s0_ready", s0_mod_ready, (k != 1));
            chk("rr_s1_ready", s1_mod_ready, (k == 1));
            chk("rr_no_valid_yet", m_em_mod_valid, 0);
            step();
            #1;
            chk("rr_em_valid", m_em_mod_valid, 1);
            chk("rr_st_valid", m_st_mod_valid, 0);
            chk("rr_grant", grant_id, (k == 1));
            chk("rr_addr", m_mod_addr, (k == 1) ? 24'h000B0B : 24'h000A0A);
            chk("rr_busy", busy, 1);
            step();
        end
        s0_mod_valid = 1'b0; s1_mod_valid = 1'b0; m_em_mod_ready = 1'b0;
        #1;
        chk("rr_idle", busy, 0);

        // s1 state-table read with a slow target.
        @(negedge clk);
        s1_mod_valid = 1'b1; s1_mod_opcode = 4'hD; s1_mod_addr = 24'h123456;
        #1;
        chk("st_s1_ready", s1_mod_ready, 1);
        step();
        s1_mod_valid = 1'b0; s1_mod_addr = 24'h0;
        for (int k = 0; k < 5; k++) step();
        #1;
        chk("st_valid", m_st_mod_valid, 1);
        chk("st_em_valid", m_em_mod_valid, 0);
        chk("st_addr_hold", m_mod_addr, 24'h123456);
        chk("st_cmd_bready", m_st_mod_bready, 0);
        @(negedge clk);
        m_st_mod_ready = 1'b1;
        step();
        m_st_mod_ready = 1'b0;
        m_st_mod_bvalid = 1'b1; m_st_mod_bdata = 134'h1234; s1_mod_bready = 1'b1;
        #1;
        chk("st_bvalid", s1_mod_bvalid, 1);
        chk("st_bdata", s1_mod_bdata, 134'h1234);
        chk("st_s0_bvalid", s0_mod_bvalid, 0);
        chk("st_bready", m_st_mod_bready, 1);
        chk("st_em_bready", m_em_mod_bready, 0);
        chk("st_grant", grant_id, 1);
        step();
        m_st_mod_bvalid = 1'b0; s1_mod_bready = 1'b0;
        #1;
        chk("st_done", busy, 0);

        // s0 EM read that times out; owner stalls 10 cycles with s1 waiting.
        @(negedge clk);
        s0_mod_valid = 1'b1; s0_mod_opcode = 4'h1; m_em_mod_ready = 1'b1;
        step();
        s0_mod_valid = 1'b0;
        step();
        m_em_mod_ready = 1'b0;
        for (int k = 0; k < TO - 1; k++) begin
            #1;
            chk("to_wait_bvalid", s0_mod_bvalid, 0);
            step();
        end
        #1;
        chk("to_bvalid", s0_mod_bvalid, 1);
        chk("to_bdata", s0_mod_bdata, 0);
        chk("to_em_bready", m_em_mod_bready, 0);
        s1_mod_valid = 1'b1; s1_mod_opcode = 4'h0;
        for (int k = 0; k < 10; k++) step();
        #1;
        chk("stall_bvalid", s0_mod_bvalid, 1);
        chk("stall_bdata", s0_mod_bdata, 0);
        chk("stall_busy", busy, 1);
        chk("stall_s1_ready", s1_mod_ready, 0);
        chk("stall_tocnt", timeout_count, 1);
        s1_mod_valid = 1'b0;
        @(negedge clk);
        s0_mod_bready = 1'b1;
        step();
        s0_mod_bready = 1'b0;
        m_em_mod_bvalid = 1'b1; m_em_mod_bdata = 134'h77;
        #1;
        chk("drain_busy", busy, 0);
        chk("drain_em_bready", m_em_mod_bready, 1);
        chk("drain_s0_bvalid", s0_mod_bvalid, 0);
        step();
        m_em_mod_bvalid = 1'b0;

        // Real data arriving on the expiry cycle wins.
        s0_mod_valid = 1'b1; m_em_mod_ready = 1'b1;
        step();
        s0_mod_valid = 1'b0;
        step();
        m_em_mod_ready = 1'b0;
        for (int k = 0; k < TO - 1; k++) step();
        m_em_mod_bvalid = 1'b1; m_em_mod_bdata = 134'hABCD; s0_mod_bready = 1'b1;
        #1;
        chk("race_bvalid", s0_mod_bvalid, 1);
        chk("race_bdata", s0_mod_bdata, 134'hABCD);
        chk("race_em_bready", m_em_mod_bready, 1);
        step();
        m_em_mod_bvalid = 1'b0; s0_mod_bready = 1'b0;
        #1;
        chk("race_tocnt", timeout_count, 1);
        chk("race_idle", busy, 0);

        // Reset during RESP abandons the read; s0 (last granted) still wins the next tie.
        @(negedge clk);
        s0_mod_valid = 1'b1; m_em_mod_ready = 1'b1;
        step();
        s0_mod_valid = 1'b0;
        step();
        m_em_mod_ready = 1'b0;
        step();
        m_em_mod_bvalid = 1'b1; m_em_mod_bdata = 134'h55;
        #1;
        chk("pre_rst_busy", busy, 1);
        rst = 1'b1;
        #1;
        chk("rst_resp_bvalid", s0_mod_bvalid, 0);
        step();
        rst = 1'b0; m_em_mod_bvalid = 1'b0;
        s0_mod_valid = 1'b1; s1_mod_valid = 1'b1; s0_mod_opcode = 4'h0; s1_mod_opcode = 4'h0;
        #1;
        chk("post_rst_busy", busy, 0);
        chk("post_rst_bvalid", s0_mod_bvalid, 0);
        chk("post_rst_s0_wins", s0_mod_ready, 1);
        chk("post_rst_s1_loses", s1_mod_ready, 0);
        chk("post_rst_tocnt", timeout_count, 0);
        step();
        s0_mod_valid = 1'b0; s1_mod_valid = 1'b0;
        #1;
        chk("post_rst_grant", grant_id, 0);
        chk("post_rst_em_valid", m_em_mod_valid, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
